// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: owns the board memory port during the clear phase.
// Scans rows bottom-up and stops a row's scan at its first empty cell.
// A full row is removed by copying every row above it down by one and then
// blanking the top row. The same row index is scanned again afterwards,
// because a different row has now moved into it.
module line_clear_ctrl #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int XW   = 4,
    parameter int YW   = 5
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [YW-1:0] lines_cleared,
    output logic [XW-1:0] board_rx,
    output logic [YW-1:0] board_ry,
    input  logic          board_rdata,
    output logic          board_we,
    output logic [XW-1:0] board_wx,
    output logic [YW-1:0] board_wy,
    output logic          board_wdata
);

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_TOP  = YW'(ROWS - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [2:0] {
        IDLE, SCAN_RD, SCAN_CHK, COPY_RD, COPY_WR, CLR_TOP, DONE
    } state_t;

    state_t        state, state_n;
    logic [YW-1:0] r, r_n;        // row being scanned
    logic [YW-1:0] y, y_n;        // destination row of the shift
    logic [XW-1:0] x, x_n;        // column, shared by scan, copy and clear
    logic [YW-1:0] lc_n;

    // state and counter registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            r             <= '0;
            y             <= '0;
            x             <= '0;
            lines_cleared <= '0;
        end else begin
            state         <= state_n;
            r             <= r_n;
            y             <= y_n;
            x             <= x_n;
            lines_cleared <= lc_n;
        end
    end

    // next-state and counter updates
    always_comb begin
        state_n = state;
        r_n     = r;
        y_n     = y;
        x_n     = x;
        lc_n    = lines_cleared;
        case (state)
            IDLE: begin
                if (start) begin
                    r_n     = Y_TOP;
                    x_n     = '0;
                    lc_n    = '0;
                    state_n = SCAN_RD;
                end
            end
            SCAN_RD: state_n = SCAN_CHK;
            SCAN_CHK: begin
                if (!board_rdata) begin
                    x_n = '0;
                    if (r == '0) begin
                        state_n = DONE;
                    end else begin
                        r_n     = r - Y_ONE;
                        state_n = SCAN_RD;
                    end
                end else if (x != X_LAST) begin
                    x_n     = x + X_ONE;
                    state_n = SCAN_RD;
                end else begin
                    lc_n    = lines_cleared + Y_ONE;
                    y_n     = r;
                    x_n     = '0;
                    state_n = (r != '0) ? COPY_RD : CLR_TOP;
                end
            end
            COPY_RD: state_n = COPY_WR;
            COPY_WR: begin
                if (x != X_LAST) begin
                    x_n     = x + X_ONE;
                    state_n = COPY_RD;
                end else if (y > Y_ONE) begin
                    y_n     = y - Y_ONE;
                    x_n     = '0;
                    state_n = COPY_RD;
                end else begin
                    x_n     = '0;
                    state_n = CLR_TOP;
                end
            end
            CLR_TOP: begin
                if (x != X_LAST) begin
                    x_n = x + X_ONE;
                end else begin
                    x_n     = '0;
                    state_n = SCAN_RD;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // memory port and handshake outputs; only wdata sees rdata, during a copy
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        board_rx    = '0;
        board_ry    = '0;
        board_we    = 1'b0;
        board_wx    = '0;
        board_wy    = '0;
        board_wdata = 1'b0;
        case (state)
            SCAN_RD: begin
                board_rx = x;
                board_ry = r;
            end
            COPY_RD: begin
                board_rx = x;
                board_ry = y - Y_ONE;
            end
            COPY_WR: begin
                board_we    = 1'b1;
                board_wx    = x;
                board_wy    = y;
                board_wdata = board_rdata;
            end
            CLR_TOP: begin
                board_we = 1'b1;
                board_wx = x;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: randomized and directed passes against a row-level
// model of the clear pass (row fullness, shift order, cycle costs).
module tb_line_clear_ctrl;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int XW   = 4;
    localparam int YW   = 5;

    logic          CLOCK_50 = 1'b0;
    logic          resetn   = 1'b0;
    logic          start    = 1'b0;
    logic          busy, done, board_we, board_wdata;
    logic [YW-1:0] lines_cleared, board_ry, board_wy;
    logic [XW-1:0] board_rx, board_wx;
    logic          board_rdata = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .busy(busy),
        .done(done), .lines_cleared(lines_cleared), .board_rx(board_rx),
        .board_ry(board_ry), .board_rdata(board_rdata), .board_we(board_we),
        .board_wx(board_wx), .board_wy(board_wy), .board_wdata(board_wdata)
    );

    // board memory: registered read, one write per cycle, bulk load from tb
    logic [COLS-1:0] mem      [ROWS];
    logic [COLS-1:0] ld_board [ROWS];
    logic [COLS-1:0] mb       [ROWS];
    bit              ld_req = 1'b0;

    always @(posedge CLOCK_50) begin
        if (int'(board_ry) < ROWS && int'(board_rx) < COLS)
            board_rdata <= mem[board_ry][board_rx];
        else
            board_rdata <= 1'b0;
        if (ld_req) begin
            for (int i = 0; i < ROWS; i++) mem[i] <= ld_board[i];
        end else if (board_we && int'(board_wy) < ROWS && int'(board_wx) < COLS) begin
            mem[board_wy][board_wx] <= board_wdata;
        end
    end

    int cyc = 0;
    always @(posedge CLOCK_50) cyc++;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // expected write stream and pass timing
    int wq_x[$];
    int wq_y[$];
    int wq_d[$];
    bit mon_en   = 1'b0;
    int t0       = 0;
    int exp_n    = 0;
    int done_cnt = 0;
    int mk;

    // per-cycle compare against the model's timing and write stream
    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            mk = cyc - t0;
            chk("busy", int'(busy), int'(mk >= 1 && mk <= exp_n + 1));
            chk("done", int'(done), int'(mk == exp_n + 1));
            if (done) done_cnt++;
            if (board_we) begin
                if (wq_x.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    chk("wx", int'(board_wx), wq_x.pop_front());
                    chk("wy", int'(board_wy), wq_y.pop_front());
                    chk("wdata", int'(board_wdata), wq_d.pop_front());
                end
            end
        end
    end

    // whole-pass model over mb: returns busy cycles before DONE and rows removed
    task automatic model_pass(output int cost, output int lines);
        int  r;
        int  e;
        bit  go;
        cost = 0;
        lines = 0;
        wq_x.delete(); wq_y.delete(); wq_d.delete();
        r  = ROWS - 1;
        go = 1'b1;
        while (go) begin
            if (&mb[r]) begin
                lines++;
                cost += 2*COLS + 2*COLS*r + COLS;
                for (int yy = r; yy >= 1; yy--) begin
                    for (int xx = 0; xx < COLS; xx++) begin
                        wq_x.push_back(xx); wq_y.push_back(yy);
                        wq_d.push_back(int'(mb[yy-1][xx]));
                        mb[yy][xx] = mb[yy-1][xx];
                    end
                end
                for (int xx = 0; xx < COLS; xx++) begin
                    wq_x.push_back(xx); wq_y.push_back(0); wq_d.push_back(0);
                    mb[0][xx] = 1'b0;
                end
            end else begin
                e = 0;
                while (mb[r][e]) e++;
                cost += 2*(e + 1);
                if (r == 0) go = 1'b0;
                else r--;
            end
        end
    endtask

    task automatic load(input logic [COLS-1:0] b [ROWS]);
        for (int i = 0; i < ROWS; i++) ld_board[i] = b[i];
        @(negedge CLOCK_50);
        ld_req = 1'b1;
        @(negedge CLOCK_50);
        ld_req = 1'b0;
    endtask

    // run one pass on the current memory and check it end to end
    task automatic run_pass(input bit noise, output int n, output int l, output int nw);
        int k;
        for (int i = 0; i < ROWS; i++) mb[i] = mem[i];
        model_pass(n, l);
        nw       = wq_x.size();
        exp_n    = n;
        done_cnt = 0;
        @(negedge CLOCK_50);
        t0     = cyc;
        start  = 1'b1;
        mon_en = 1'b1;
        k      = 0;
        while (k < n + 3) begin
            @(negedge CLOCK_50);
            k = cyc - t0;
            start = (noise && k <= n + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        mon_en = 1'b0;
        chk("done_pulses", done_cnt, 1);
        chk("writes_left", wq_x.size(), 0);
        chk("lines_cleared", int'(lines_cleared), l);
        chk("idle_after", int'(busy), 0);
        for (int i = 0; i < ROWS; i++) chk("final_row", int'(mem[i]), int'(mb[i]));
    endtask

    logic [COLS-1:0] b [ROWS];
    int n, l, nw, ones, w;

    initial begin
        for (int i = 0; i < ROWS; i++) b[i] = '0;
        repeat (2) @(negedge CLOCK_50);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(board_we), 0);
        chk("rst_lines", int'(lines_cleared), 0);
        chk("rst_addr", int'(board_rx) + int'(board_ry) + int'(board_wx) + int'(board_wy), 0);
        resetn = 1'b1;

        // empty board: one read per row, no writes
        load(b);
        run_pass(1'b0, n, l, nw);
        chk("pin_empty_cost", n, 40);
        chk("pin_empty_writes", nw, 0);

        // row 19 full plus (3,18), with start noise while busy
        b[19] = '1; b[18] = 10'b0000001000;
        load(b);
        run_pass(1'b1, n, l, nw);
        chk("pin_r19_cost", n, 450);
        chk("pin_r19_writes", nw, 200);
        chk("pin_r19_lines", l, 1);
        chk("pin_r19_cell", int'(mem[19]), 8);

        // rows 18,19 full plus (0,17)
        for (int i = 0; i < ROWS; i++) b[i] = '0;
        b[19] = '1; b[18] = '1; b[17] = 10'b1;
        load(b);
        run_pass(1'b0, n, l, nw);
        chk("pin_two_lines", l, 2);
        ones = 0;
        for (int i = 0; i < ROWS; i++) ones += $countones(mb[i]);
        chk("pin_two_ones", ones, 1);
        chk("pin_two_cell", int'(mb[19]), 1);

        // only row 0 full: clear of the top row, no copies
        for (int i = 0; i < ROWS; i++) b[i] = '0;
        b[0] = '1;
        load(b);
        run_pass(1'b0, n, l, nw);
        chk("pin_top_writes", nw, 10);
        chk("pin_top_cost", n, 70);
        chk("pin_top_lines", l, 1);

        // random boards
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < ROWS; i++)
                b[i] = ($urandom_range(0, 3) == 0) ? '1 : COLS'($urandom);
            load(b);
            run_pass(1'b1, n, l, nw);
        end

        // reset in the middle of a copy, then a normal pass
        for (int i = 0; i < ROWS; i++) b[i] = COLS'($urandom);
        b[19] = '1;
        load(b);
        @(negedge CLOCK_50); start = 1'b1;
        @(negedge CLOCK_50); start = 1'b0;
        w = 0;
        while (!(board_we && board_wy != '0) && w < 1000) begin
            @(negedge CLOCK_50);
            w++;
        end
        chk("reach_copy", int'(w < 1000), 1);
        resetn = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_we", int'(board_we), 0);
        chk("abort_lines", int'(lines_cleared), 0);
        @(posedge CLOCK_50); #1;
        chk("abort_hold", int'(busy) + int'(board_we) + int'(done), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        run_pass(1'b0, n, l, nw);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
Sequencer that owns the board memory port during the game FSM's clear phase. On a start pulse it scans the 10x20 board bottom-up and detects full rows. For each full row it shifts every row above it down by one, clears the top row, and counts the rows removed. It sits between the game logic (start/done handshake) and the single-port board memory (1-cycle registered read, 1-cycle write).

Parameters:
COLS, 10, board width in cells (x = 0..COLS-1)
ROWS, 20, board height in cells (y = 0..ROWS-1, y=0 is top)
XW, 4, x address width
YW, 5, y address width

Ports:
CLOCK_50  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  1-cycle request to run a clear pass; sampled only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse when the pass completes
lines_cleared  output  YW  full rows removed by the last pass; held until next accepted start
board_rx  output  XW  read x address
board_ry  output  YW  read y address
board_rdata  input  1  cell data for the address presented in the previous cycle
board_we  output  1  write enable, 1 cycle per cell
board_wx  output  XW  write x address
board_wy  output  YW  write y address
board_wdata  output  1  write data

Behaviour:
- Reset (async, resetn=0) values: state IDLE, busy=0, done=0, lines_cleared=0, board_we=0, board_wdata=0, all addresses 0, internal row/col/shift counters 0.
- Read timing: address driven in cycle n; board_rdata is sampled in cycle n+1.
- All outputs decode from registered state and counters only. There is no combinational path from start or board_rdata to any output, except board_wdata in COPY_WR, which equals board_rdata.
- States:
  - IDLE: on start=1, set row r=ROWS-1, x=0, lines_cleared=0; go to SCAN_RD. Otherwise stay.
  - SCAN_RD: drive (x,r) on the read port; go to SCAN_CHK.
  - SCAN_CHK: sample rdata.
    - rdata=0: row is not full. If r=0, go to DONE; otherwise r<=r-1, x<=0, go to SCAN_RD (early exit on the first empty cell).
    - rdata=1 and x<COLS-1: x<=x+1, go to SCAN_RD.
    - rdata=1 and x=COLS-1: row is full. lines_cleared<=lines_cleared+1; set y=r, x=0. Go to COPY_RD if r>0, else CLR_TOP.
  - COPY_RD: drive read (x,y-1); go to COPY_WR.
  - COPY_WR: board_we=1, write (x,y) with board_wdata=board_rdata.
    - x<COLS-1: x+1, go to COPY_RD.
    - x=COLS-1 and y>1: y-1, x=0, go to COPY_RD.
    - x=COLS-1 and y=1: x=0, go to CLR_TOP.
  - CLR_TOP: board_we=1, board_wy=0, board_wx=x, board_wdata=0; one cell per cycle. After x=COLS-1: x=0, go to SCAN_RD with r unchanged, so the same row is re-scanned after the shift.
  - DONE: done=1 for one cycle; go to IDLE.
- board_we=0 in every state except COPY_WR and CLR_TOP.
- Cycle costs: empty-cell row exit = 2 cycles. Full-row scan = 2*COLS cycles. Shift of full row r = 2*COLS*r cycles. Top-row clear = COLS cycles.
- Arithmetic: lines_cleared max is ROWS and fits in YW bits, so no saturation is needed. The counters never wrap: r=0 and y=1 are the explicit terminal checks.
- start while busy (including during DONE) is ignored and is not queued.
- Reset mid-pass aborts immediately. Board contents may be partially shifted; the game FSM resets the board along with this block.
- Termination is guaranteed: each full row removed adds a cleared top row, and a pass over an all-empty row 0 exits.

Test Plan:
- Empty board; start at cycle 0 -> busy=1 for cycles 1-41, only reads (1 per row, x=0, rows 19..0), no board_we, done pulse at cycle 41, lines_cleared=0, IDLE at cycle 42.
- Row 19 all ones, plus cell (3,18)=1, rest empty -> done at cycle 451 (20+380+10+2+38 busy cycles plus DONE). Final board: only (3,19)=1. lines_cleared=1. Exactly 200 writes.
- Rows 18 and 19 full, (0,17)=1 -> final board: only (0,19)=1; lines_cleared=2. Row 19 is re-scanned after each shift.
- Row 0 only full -> no COPY states; 10 CLR_TOP writes of 0 to row 0; row 0 re-scanned; lines_cleared=1; done.
- Pulse start again during busy at random cycles -> no effect on sequence or final board; exactly one done pulse.
- Assert resetn=0 mid-COPY_WR -> next edge shows busy=0, done=0, board_we=0, lines_cleared=0, state IDLE. A new start after release runs a full pass normally.
